// File: rtl/pulse_interval_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter_pkg
// Shared definitions for the pulse interval meter and the delay generator that
// feeds it.
//   - PIM_CNT_W_DEFAULT : default interval counter width. The delay generator
//                         uses the same width, so one measured count maps
//                         directly onto one programmed delay.
//   - pim_state_t       : measurement FSM state encoding.
//   - pim_rise()        : rising-edge helper (current & ~previous).
// Optional feature macro used by the files that import this package:
//   PULSE_METER_SYNC_EN
// -----------------------------------------------------------------------------
package pulse_interval_meter_pkg;

  localparam int unsigned PIM_CNT_W_DEFAULT = 8;

  localparam logic [1:0] PIM_ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] PIM_ST_COUNT_ENC = 2'd1;
  localparam logic [1:0] PIM_ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = PIM_ST_IDLE_ENC,
    ST_COUNT = PIM_ST_COUNT_ENC,
    ST_DONE  = PIM_ST_DONE_ENC
  } pim_state_t;

  // A level held high yields exactly one cycle of rise.
  function automatic logic pim_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/pulse_interval_meter_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter_sync_edge_detect
// Conditions one strobe input and produces a single-cycle rising-edge pulse.
// With PULSE_METER_SYNC_EN defined the input is treated as asynchronous and
// passes through a 2-flop synchronizer first (2 cycles of latency). Without
// it the input is assumed synchronous to clk and only the previous-value
// register is used.
// Ports:
//   clk      : system clock, posedge
//   reset_n  : asynchronous active-low reset, clears all flops
//   sig_in   : raw strobe input
//   rise_o   : high for one cycle when the conditioned strobe rises
// -----------------------------------------------------------------------------
module pulse_interval_meter_sync_edge_detect
  import pulse_interval_meter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise_o
);

  logic cond_s;
  logic prev_d;
  logic prev_q;

`ifdef PULSE_METER_SYNC_EN
  logic meta_d;
  logic meta_q;
  logic sync_d;
  logic sync_q;

  // Synchronizer next-state values.
  always_comb begin
    meta_d = sig_in;
    sync_d = meta_q;
  end

  // Two-flop synchronizer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign cond_s = sync_q;
`else
  assign cond_s = sig_in;
`endif

  // Previous-value next state.
  always_comb begin
    prev_d = cond_s;
  end

  // Previous-value register for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = pim_rise(cond_s, prev_q);

endmodule

// File: rtl/pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter
// Measures the number of clk cycles between a rising edge on start_in and the
// next rising edge on stop_in, and presents the result with a valid/ack
// handshake. Intervals longer than 2^CNT_W-1 cycles saturate and set overflow
// without waiting for stop.
// Optional feature macro: PULSE_METER_SYNC_EN (2-flop input synchronizers;
// both edges are delayed equally, so counts are unchanged).
// Parameters:
//   CNT_W    : width of the count result
// Ports:
//   clk      : system clock, posedge
//   reset_n  : asynchronous active-low reset, clears all state
//   start_in : start strobe, rising edge significant
//   stop_in  : stop strobe, rising edge significant
//   ack      : consumer accepts the result (only while valid=1)
//   busy     : measurement in progress
//   valid    : result available, held until ack
//   count    : measured interval in clk cycles
//   overflow : interval saturated, qualifies count while valid=1
// -----------------------------------------------------------------------------
module pulse_interval_meter
  import pulse_interval_meter_pkg::*;
#(
  parameter int unsigned CNT_W = PIM_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  pim_state_t       state_d;
  pim_state_t       state_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             valid_d;
  logic             valid_q;
  logic             busy_d;
  logic             busy_q;
  logic             start_rise_s;
  logic             stop_rise_s;

  pulse_interval_meter_sync_edge_detect u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_in  (start_in),
    .rise_o  (start_rise_s)
  );

  pulse_interval_meter_sync_edge_detect u_stop_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_in  (stop_in),
    .rise_o  (stop_rise_s)
  );

  // cnt_q holds (cycles since start edge) - 1 while counting, so the value
  // reported on a stop edge is cnt_q + 1. It therefore never exceeds
  // CNT_MAX - 1 and cannot wrap.
  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Next-state and datapath logic for the measurement FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // Start wins over a simultaneous stop; a lone stop is ignored.
        if (start_rise_s) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        // Further start edges are ignored here: no restart.
        if (stop_rise_s) begin
          state_d = ST_DONE;
          count_d = cnt_inc_s;
          ovf_d   = 1'b0;
        end else if (cnt_inc_s == CNT_MAX) begin
          // A stop now could at best report CNT_MAX + 1: saturate.
          state_d = ST_DONE;
          count_d = CNT_MAX;
          ovf_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_DONE: begin
        // Edges arriving here are dropped; count survives the ack.
        if (ack) begin
          state_d = ST_IDLE;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        ovf_d   = 1'b0;
      end
    endcase
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_COUNT);
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_interval_meter
// Directed bench for pulse_interval_meter built with CNT_W=4 (saturation at
// 15). Inputs change 1ns after a posedge and outputs are checked at that same
// point, before the next edge. LAT is the number of sampling edges from an
// input rising to the FSM reacting: 1 normally, 3 with PULSE_METER_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_pulse_interval_meter;

`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset_n;
  logic       start_in;
  logic       stop_in;
  logic       ack;
  logic       busy;
  logic       valid;
  logic [3:0] count;
  logic       overflow;

  int n_cmp;
  int n_err;

  pulse_interval_meter #(.CNT_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_in (start_in),
    .stop_in  (stop_in),
    .ack      (ack),
    .busy     (busy),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b1;
    start_in = 1'b0;
    stop_in  = 1'b0;
    ack      = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chkc("rst_count", count, 4'd0);
    chk1("rst_ovf", overflow, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Reset in the middle of a measurement.
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(LAT - 1);
    chk1("a_busy_on", busy, 1'b1);
    tick(5);
    reset_n = 1'b0;
    #1;
    chk1("a_rst_busy", busy, 1'b0);
    chk1("a_rst_valid", valid, 1'b0);
    chkc("a_rst_count", count, 4'd0);
    chk1("a_rst_ovf", overflow, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    stop_in = 1'b1;
    tick(1);
    stop_in = 1'b0;
    tick(LAT + 3);
    chk1("a_stop_busy", busy, 1'b0);
    chk1("a_stop_valid", valid, 1'b0);

    // Basic interval of 10 with exact valid latency, hold and ack.
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(9);
    stop_in = 1'b1;
    tick(LAT - 1);
    chk1("b_valid_early", valid, 1'b0);
    tick(1);
    stop_in = 1'b0;
    chk1("b_valid", valid, 1'b1);
    chkc("b_count", count, 4'd10);
    chk1("b_ovf", overflow, 1'b0);
    chk1("b_busy", busy, 1'b0);
    tick(6);
    chk1("b_hold_valid", valid, 1'b1);
    chkc("b_hold_count", count, 4'd10);
    do_ack();
    chk1("b_ack_valid", valid, 1'b0);
    chkc("b_ack_count", count, 4'd10);
    tick(2);

    // Minimum interval with both levels held high.
    start_in = 1'b1;
    tick(1);
    stop_in = 1'b1;
    tick(20);
    chk1("c_valid", valid, 1'b1);
    chkc("c_count", count, 4'd1);
    do_ack();
    tick(5);
    chk1("c_once_valid", valid, 1'b0);
    chk1("c_once_busy", busy, 1'b0);
    start_in = 1'b0;
    stop_in  = 1'b0;
    tick(LAT + 2);

    // Overflow: no stop, saturate at 15.
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(LAT - 1 + 14);
    chk1("d_pre_valid", valid, 1'b0);
    chk1("d_pre_busy", busy, 1'b1);
    tick(1);
    chk1("d_valid", valid, 1'b1);
    chkc("d_count", count, 4'd15);
    chk1("d_ovf", overflow, 1'b1);
    stop_in = 1'b1;
    tick(1);
    stop_in = 1'b0;
    tick(LAT + 2);
    chk1("d_late_valid", valid, 1'b1);
    chk1("d_late_ovf", overflow, 1'b1);
    do_ack();
    chk1("d_ack_valid", valid, 1'b0);
    chk1("d_ack_ovf", overflow, 1'b0);
    chkc("d_ack_count", count, 4'd15);
    tick(LAT + 2);
    chk1("d_lost_valid", valid, 1'b0);
    chk1("d_lost_busy", busy, 1'b0);

    // Exactly 15 cycles: full range without overflow.
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(14);
    stop_in = 1'b1;
    tick(LAT);
    stop_in = 1'b0;
    chk1("m_valid", valid, 1'b1);
    chkc("m_count", count, 4'd15);
    chk1("m_ovf", overflow, 1'b0);
    do_ack();
    tick(2);

    // Simultaneous start+stop, extra start during COUNT, stop 7 later.
    start_in = 1'b1;
    stop_in  = 1'b1;
    tick(1);
    start_in = 1'b0;
    stop_in  = 1'b0;
    tick(2);
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(3);
    stop_in = 1'b1;
    tick(LAT - 1);
    chk1("e_valid_early", valid, 1'b0);
    tick(1);
    stop_in = 1'b0;
    chk1("e_valid", valid, 1'b1);
    chkc("e_count", count, 4'd7);
    do_ack();
    tick(2);

    // Lone stop in IDLE.
    stop_in = 1'b1;
    tick(1);
    stop_in = 1'b0;
    tick(LAT + 3);
    chk1("f_valid", valid, 1'b0);
    chk1("f_busy", busy, 1'b0);

    // Interval of 12 with exact valid latency.
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(11);
    stop_in = 1'b1;
    tick(LAT - 1);
    chk1("g_valid_early", valid, 1'b0);
    chk1("g_busy", busy, 1'b1);
    tick(1);
    stop_in = 1'b0;
    chk1("g_valid", valid, 1'b1);
    chkc("g_count", count, 4'd12);
    do_ack();
    chk1("g_ack_valid", valid, 1'b0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
